// File: rtl/wbcon_pkg.sv
// rtl/wbcon_pkg.sv - Shared Wishbone command executor constants, op decode and parser states.
package wbcon_pkg;

    localparam logic [5:0] WBCON_OP_SYNC      = 6'b101000;
    localparam int         WBCON_OP_WR_BIT    = 0;
    localparam int         WBCON_OP_AINCR_BIT = 1;

    typedef enum logic [2:0] {
        ST_OP    = 3'd0,
        ST_ADDR  = 3'd1,
        ST_CNT   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DRAIN = 3'd4
    } parser_state_t;

    function automatic logic wbcon_op_ok(input logic [7:0] op);
        return op[7:2] == WBCON_OP_SYNC;
    endfunction

endpackage

// File: rtl/wbcon_rx_timeout.sv
// rtl/wbcon_rx_timeout.sv - Inter-byte idle counter; pulses expire after TIMEOUT_CYCLES enabled idle cycles.
module wbcon_rx_timeout #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] count;

    assign expire = enable && !clear && (count == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || expire || !enable) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wbcon_rx_parser.sv
// rtl/wbcon_rx_parser.sv - Parses host Rx bytes into MREQ commands and forwards write payload.
// Optional header timeout enabled by defining WBCON_RX_TIMEOUT_EN.
module wbcon_rx_parser
    import wbcon_pkg::*;
#(
    parameter int COUNT_WIDTH    = 8,
    parameter int WB_ADDR_WIDTH  = 24,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx_valid,
    input  logic [7:0]               i_rx_data,
    output logic                     o_rx_ready,
    output logic                     o_pl_valid,
    output logic [7:0]               o_pl_data,
    input  logic                     i_pl_ready,
    output logic                     o_mreq_valid,
    input  logic                     i_mreq_ready,
    output logic [WB_ADDR_WIDTH-1:0] o_mreq_addr,
    output logic [COUNT_WIDTH-1:0]   o_mreq_cnt,
    output logic                     o_mreq_wr,
    output logic                     o_mreq_aincr,
    output logic                     o_sync_err
);

    localparam int WORD_SIZE  = (WB_DATA_WIDTH + 7) / 8;
    localparam int ADDR_BYTES = (WB_ADDR_WIDTH + 7) / 8;
    localparam int CNT_BYTES  = (COUNT_WIDTH + 7) / 8;
    localparam int MAX_BYTES  = (ADDR_BYTES > CNT_BYTES) ? ADDR_BYTES : CNT_BYTES;
    localparam int IDX_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int REM_W      = COUNT_WIDTH + $clog2(WORD_SIZE) + 1;

    parser_state_t           state, state_next;
    logic [IDX_W-1:0]        byte_idx;
    logic [8*ADDR_BYTES-1:0] addr_q;
    logic [8*CNT_BYTES-1:0]  cnt_q, cnt_new;
    logic [REM_W-1:0]        pl_rem, rem_load;
    logic                    op_wr, op_aincr, mreq_wr, mreq_aincr, sync_err;
    logic                    rx_hs, pl_hs, pl_active, rem_last, op_ok;
    logic                    addr_last, cnt_last, tmo_expire;

    assign op_ok     = wbcon_op_ok(i_rx_data);
    assign pl_active = (pl_rem != '0);
    assign rem_last  = (pl_rem == REM_W'(1));
    assign addr_last = (byte_idx == IDX_W'(ADDR_BYTES - 1));
    assign cnt_last  = (byte_idx == IDX_W'(CNT_BYTES - 1));
    assign rx_hs     = i_rx_valid && o_rx_ready;
    assign pl_hs     = o_pl_valid && i_pl_ready;

    assign o_pl_data    = i_rx_data;
    assign o_mreq_addr  = addr_q[WB_ADDR_WIDTH-1:0];
    assign o_mreq_cnt   = cnt_q[COUNT_WIDTH-1:0];
    assign o_mreq_wr    = mreq_wr;
    assign o_mreq_aincr = mreq_aincr;
    assign o_sync_err   = sync_err;

    // Payload length is computed from the count including the byte arriving now.
    always_comb begin
        cnt_new = cnt_q;
        cnt_new[8*(CNT_BYTES-1) +: 8] = i_rx_data;
        rem_load = (REM_W'(cnt_new[COUNT_WIDTH-1:0]) + REM_W'(1)) * REM_W'(WORD_SIZE);
    end

`ifdef WBCON_RX_TIMEOUT_EN
    wbcon_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (rx_hs || (state == ST_OP)),
        .enable((state == ST_ADDR) || (state == ST_CNT)),
        .expire(tmo_expire)
    );
`else
    assign tmo_expire = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_OP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_OP:    if (rx_hs && op_ok) state_next = ST_ADDR;
            ST_ADDR:  if (tmo_expire) state_next = ST_OP;
                      else if (rx_hs && addr_last) state_next = ST_CNT;
            ST_CNT:   if (tmo_expire) state_next = ST_OP;
                      else if (rx_hs && cnt_last) state_next = ST_ISSUE;
            ST_ISSUE: if (i_mreq_ready)
                          state_next = (!pl_active || (pl_hs && rem_last)) ? ST_OP : ST_DRAIN;
            ST_DRAIN: if (!pl_active || (pl_hs && rem_last)) state_next = ST_OP;
            default:  state_next = ST_OP;
        endcase
    end

    // Once the header is complete, the host stream is steered straight to the payload port.
    always_comb begin
        o_rx_ready   = 1'b0;
        o_pl_valid   = 1'b0;
        o_mreq_valid = 1'b0;
        case (state)
            ST_OP, ST_ADDR, ST_CNT: o_rx_ready = 1'b1;
            ST_ISSUE: begin
                o_mreq_valid = 1'b1;
                o_rx_ready   = pl_active && i_pl_ready;
                o_pl_valid   = pl_active && i_rx_valid;
            end
            ST_DRAIN: begin
                o_rx_ready = pl_active && i_pl_ready;
                o_pl_valid = pl_active && i_rx_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_idx   <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            pl_rem     <= '0;
            op_wr      <= 1'b0;
            op_aincr   <= 1'b0;
            mreq_wr    <= 1'b0;
            mreq_aincr <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            sync_err <= ((state == ST_OP) && rx_hs && !op_ok) || tmo_expire;
            case (state)
                ST_OP: if (rx_hs && op_ok) begin
                    op_wr    <= i_rx_data[WBCON_OP_WR_BIT];
                    op_aincr <= i_rx_data[WBCON_OP_AINCR_BIT];
                    byte_idx <= '0;
                end
                ST_ADDR: if (rx_hs) begin
                    for (int k = 0; k < ADDR_BYTES; k++)
                        if (byte_idx == IDX_W'(k)) addr_q[8*k +: 8] <= i_rx_data;
                    byte_idx <= addr_last ? '0 : byte_idx + 1'b1;
                end
                ST_CNT: if (rx_hs) begin
                    for (int k = 0; k < CNT_BYTES; k++)
                        if (byte_idx == IDX_W'(k)) cnt_q[8*k +: 8] <= i_rx_data;
                    byte_idx <= cnt_last ? '0 : byte_idx + 1'b1;
                    if (cnt_last) begin
                        mreq_wr    <= op_wr;
                        mreq_aincr <= op_aincr;
                        pl_rem     <= op_wr ? rem_load : '0;
                    end
                end
                ST_ISSUE, ST_DRAIN: if (pl_hs) pl_rem <= pl_rem - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wbcon_rx_parser.sv
// tb/tb_wbcon_rx_parser.sv - Self-checking bench for wbcon_rx_parser (frame table plus corner sequences).
module tb_wbcon_rx_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        pl_ready = 1'b1;
    logic        mreq_ready = 1'b0;
    logic        rx_ready, pl_valid, mreq_valid, mreq_wr, mreq_aincr, sync_err;
    logic [7:0]  pl_data;
    logic [23:0] mreq_addr;
    logic [7:0]  mreq_cnt;

    int          total = 0;
    int          bad = 0;
    int          sync_cnt = 0;
    bit          pl_toggle = 0;
    logic [7:0]  pl_q[$];

    always #5 clk = ~clk;

    wbcon_rx_parser #(
        .COUNT_WIDTH(8), .WB_ADDR_WIDTH(24), .WB_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_valid(rx_valid), .i_rx_data(rx_data), .o_rx_ready(rx_ready),
        .o_pl_valid(pl_valid), .o_pl_data(pl_data), .i_pl_ready(pl_ready),
        .o_mreq_valid(mreq_valid), .i_mreq_ready(mreq_ready),
        .o_mreq_addr(mreq_addr), .o_mreq_cnt(mreq_cnt),
        .o_mreq_wr(mreq_wr), .o_mreq_aincr(mreq_aincr), .o_sync_err(sync_err)
    );

    always begin
        @(negedge clk);
        #2;
        if (pl_valid && pl_ready) pl_q.push_back(pl_data);
        if (sync_err) sync_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time exceeded, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic upd_pl();
        if (pl_toggle) pl_ready = ~pl_ready;
        else pl_ready = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int limit, output bit ok);
        int n;
        @(negedge clk);
        upd_pl();
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        for (n = 0; n < limit && !rx_ready; n++) begin
            @(negedge clk);
            upd_pl();
            #1;
        end
        ok = rx_ready;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_ok(input string name, input logic [7:0] b);
        bit ok;
        send_byte(b, 50, ok);
        check(name, ok, 1'b1);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr, input logic [7:0] cnt);
        send_ok("hdr_op", op);
        send_ok("hdr_a0", addr[7:0]);
        send_ok("hdr_a1", addr[15:8]);
        send_ok("hdr_a2", addr[23:16]);
        send_ok("hdr_cnt", cnt);
    endtask

    task automatic wait_mreq(output bit ok);
        int n;
        @(negedge clk);
        #1;
        for (n = 0; n < 50 && !mreq_valid; n++) begin
            @(negedge clk);
            #1;
        end
        ok = mreq_valid;
    endtask

    task automatic check_mreq(input logic [23:0] a, input logic [7:0] c, input logic w, input logic ai);
        bit ok;
        wait_mreq(ok);
        check("mreq_valid", ok, 1'b1);
        check("mreq_addr", mreq_addr, a);
        check("mreq_cnt", mreq_cnt, c);
        check("mreq_wr", mreq_wr, w);
        check("mreq_aincr", mreq_aincr, ai);
    endtask

    task automatic ack();
        bit ok;
        wait_mreq(ok);
        check("ack_wait", ok, 1'b1);
        mreq_ready = 1'b1;
        @(posedge clk);
        #1;
        mreq_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        logic [7:0]  cnt;
        bit          toggle;
        int          e_npl;
        logic [23:0] e_addr;
        logic [7:0]  e_cnt;
        logic        e_wr;
        logic        e_aincr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit ok;
        bit data_ok;

        vecs[0] = '{8'hA2, 24'h123456, 8'h03, 1'b0, 0,  24'h123456, 8'h03, 1'b0, 1'b1};
        vecs[1] = '{8'hA1, 24'h000010, 8'h01, 1'b1, 8,  24'h000010, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'hA3, 24'hABCDEF, 8'h00, 1'b0, 4,  24'hABCDEF, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'hA0, 24'hFFFFFF, 8'hFF, 1'b0, 0,  24'hFFFFFF, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'hA1, 24'h800001, 8'h02, 1'b1, 12, 24'h800001, 8'h02, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        check("rst_mreq_valid", mreq_valid, 1'b0);
        check("rst_pl_valid", pl_valid, 1'b0);
        check("rst_sync_err", sync_err, 1'b0);
        check("rst_addr", mreq_addr, 24'h0);
        check("rst_cnt", mreq_cnt, 8'h0);
        check("rst_wr", mreq_wr, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            pl_q.delete();
            sync_cnt  = 0;
            pl_toggle = vecs[i].toggle;
            send_hdr(vecs[i].op, vecs[i].addr, vecs[i].cnt);
            for (int j = 0; j < vecs[i].e_npl; j++) send_ok("pl_accept", 8'(j + 16 * i));
            send_byte(8'hEE, 8, ok);
            check("hold_off", ok, 1'b0);
            check_mreq(vecs[i].e_addr, vecs[i].e_cnt, vecs[i].e_wr, vecs[i].e_aincr);
            check("pl_count", pl_q.size(), vecs[i].e_npl);
            data_ok = 1'b1;
            for (int j = 0; j < pl_q.size(); j++)
                if (pl_q[j] !== 8'(j + 16 * i)) data_ok = 1'b0;
            check("pl_order", data_ok, 1'b1);
            check("no_sync_err", sync_cnt, 0);
            ack();
            pl_toggle = 1'b0;
            @(negedge clk);
            #1;
            check("op_after_ack", rx_ready, 1'b1);
        end

        // Bad op bytes are dropped and resynchronise on the next valid op.
        sync_cnt = 0;
        send_ok("rs_55", 8'h55);
        send_ok("rs_ff", 8'hFF);
        send_hdr(8'hA0, 24'h000000, 8'h00);
        check_mreq(24'h0, 8'h0, 1'b0, 1'b0);
        check("resync_pulses", sync_cnt, 2);
        ack();

        // Largest count: 256 words of 4 bytes.
        pl_q.delete();
        send_hdr(8'hA1, 24'h000200, 8'hFF);
        for (int j = 0; j < 1024; j++) send_ok("big_accept", 8'(j));
        send_byte(8'hEE, 8, ok);
        check("big_hold_off", ok, 1'b0);
        check("big_count", pl_q.size(), 1024);
        check("big_last", pl_q[pl_q.size() - 1], 8'hFF);
        ack();

        // Early ack leaves 4 bytes to drain.
        pl_q.delete();
        send_hdr(8'hA1, 24'h000040, 8'h01);
        for (int j = 0; j < 4; j++) send_ok("dr_pre", 8'(j));
        ack();
        @(negedge clk);
        #1;
        check("drain_no_mreq", mreq_valid, 1'b0);
        check("drain_ready", rx_ready, 1'b1);
        for (int j = 4; j < 8; j++) send_ok("dr_post", 8'(j));
        check("drain_count", pl_q.size(), 8);
        check("drain_last", pl_q[7], 8'h07);
        @(negedge clk);
        #1;
        check("drain_to_op", rx_ready, 1'b1);
        send_hdr(8'hA2, 24'h000100, 8'h05);
        check_mreq(24'h000100, 8'h05, 1'b0, 1'b1);
        ack();

        // Ack coincides with the last payload byte.
        pl_q.delete();
        send_hdr(8'hA1, 24'h000020, 8'h00);
        for (int j = 0; j < 3; j++) send_ok("al_pre", 8'(j));
        @(negedge clk);
        pl_ready   = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'h03;
        mreq_ready = 1'b1;
        #1;
        check("al_ready", rx_ready, 1'b1);
        @(posedge clk);
        #1;
        rx_valid   = 1'b0;
        mreq_ready = 1'b0;
        @(negedge clk);
        #1;
        check("al_no_mreq", mreq_valid, 1'b0);
        check("al_op_ready", rx_ready, 1'b1);
        check("al_count", pl_q.size(), 4);

        // Asynchronous reset in the middle of a payload.
        pl_q.delete();
        send_hdr(8'hA1, 24'h000010, 8'h01);
        for (int j = 0; j < 3; j++) send_ok("rr_pre", 8'(j));
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        #1;
        check("rr_pl_active", pl_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rr_mreq_valid", mreq_valid, 1'b0);
        check("rr_pl_valid", pl_valid, 1'b0);
        check("rr_sync_err", sync_err, 1'b0);
        check("rr_addr", mreq_addr, 24'h0);
        check("rr_cnt", mreq_cnt, 8'h0);
        check("rr_wr", mreq_wr, 1'b0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_hdr(8'hA2, 24'h123456, 8'h03);
        check_mreq(24'h123456, 8'h03, 1'b0, 1'b1);
        check("rr_count", pl_q.size(), 3);
        ack();

`ifdef WBCON_RX_TIMEOUT_EN
        sync_cnt = 0;
        send_ok("tmo_op", 8'hA1);
        send_ok("tmo_a0", 8'h10);
        repeat (10) @(negedge clk);
        check("tmo_early", sync_cnt, 0);
        repeat (10) @(negedge clk);
        check("tmo_pulse", sync_cnt, 1);
        send_hdr(8'hA0, 24'h000000, 8'h00);
        check_mreq(24'h0, 8'h0, 1'b0, 1'b0);
        ack();
`else
        sync_cnt = 0;
        send_ok("idle_op", 8'hA0);
        send_ok("idle_a0", 8'h10);
        repeat (30) @(negedge clk);
        send_ok("idle_a1", 8'h00);
        send_ok("idle_a2", 8'h00);
        send_ok("idle_cnt", 8'h00);
        check_mreq(24'h000010, 8'h00, 1'b0, 1'b0);
        check("idle_no_sync", sync_cnt, 0);
        ack();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
